// File: rtl/l2_read_word_if.sv
// l2_read_word_if: request/response bundle between the L2 read path and the word streamer
interface l2_read_word_if;
  localparam int BITS_PER_WORD = 64;
  localparam int WORDS_PER_LINE = 4;
  logic                                    read_word_req_valid_in;
  logic                                    read_word_req_ready_out;
  logic [BITS_PER_WORD*WORDS_PER_LINE-1:0] read_word_line_in;
  logic [1:0]                              read_word_w_off_in;
  logic [2:0]                              read_word_b_off_in;
  logic [2:0]                              read_word_hsize_in;
  logic [2:0]                              read_word_count_in;
  logic                                    read_word_valid_out;
  logic                                    read_word_ready_in;
  logic [BITS_PER_WORD-1:0]                read_word_word_out;
  logic [1:0]                              read_word_w_off_out;
  logic                                    read_word_last_out;
  modport slave (
    input  read_word_req_valid_in, read_word_line_in, read_word_w_off_in, read_word_b_off_in,
           read_word_hsize_in, read_word_count_in, read_word_ready_in,
    output read_word_req_ready_out, read_word_valid_out, read_word_word_out,
           read_word_w_off_out, read_word_last_out
  );
  modport master (
    output read_word_req_valid_in, read_word_line_in, read_word_w_off_in, read_word_b_off_in,
           read_word_hsize_in, read_word_count_in, read_word_ready_in,
    input  read_word_req_ready_out, read_word_valid_out, read_word_word_out,
           read_word_w_off_out, read_word_last_out
  );
endinterface

// File: rtl/l2_read_word.sv
// l2_read_word: streams a latched cache line out as sub-word or wrapping full-word beats
module l2_read_word (
  input logic           clk,
  input logic           rst,
  l2_read_word_if.slave rw
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t         state_q, state_d;
  logic [255:0]   line_q, line_d;
  logic [1:0]     off_q, off_d, nxt_off;
  logic [2:0]     rem_q, rem_d;
  logic [63:0]    word_q, word_d;
  logic           last_q, last_d;
  logic [2:0]     cnt, b_al, b_eff;
  logic [3:0]     size;
  logic [63:0]    src, lane;
  // Decode the incoming request: clamped count, access size, byte lane and first-beat source word
  always_comb begin
    cnt = rw.read_word_count_in == 3'd0 ? 3'd1 : rw.read_word_count_in > 3'd4 ? 3'd4 : rw.read_word_count_in;
    size = rw.read_word_hsize_in == 3'd0 ? 4'd1 : rw.read_word_hsize_in == 3'd1 ? 4'd2 :
           rw.read_word_hsize_in == 3'd2 ? 4'd4 : 4'd8;
    b_al = rw.read_word_b_off_in & ~(size[2:0] - 3'd1);
`ifdef BIG_ENDIAN
    b_eff = 3'(4'd8 - size - {1'b0, b_al});
`else
    b_eff = b_al;
`endif
    src = rw.read_word_line_in[{rw.read_word_w_off_in, 6'b0} +: 64];
    lane = ~(64'hFFFF_FFFF_FFFF_FFFF << {size, 3'b0}) << {b_eff, 3'b0};
  end
  // Next state: latch on accept, advance the wrapping offset on every consumed beat
  always_comb begin
    state_d = state_q;
    line_d = line_q;
    off_d = off_q;
    rem_d = rem_q;
    word_d = word_q;
    last_d = last_q;
    nxt_off = off_q + 2'd1;
    if (state_q == IDLE) begin
      if (rw.read_word_req_valid_in) begin
        state_d = STREAM;
        line_d = rw.read_word_line_in;
        off_d = rw.read_word_w_off_in;
        rem_d = cnt;
        word_d = cnt == 3'd1 ? src & lane : src;
        last_d = cnt == 3'd1;
      end
    end else if (rw.read_word_ready_in) begin
      if (last_q) begin
        state_d = IDLE;
        last_d = 1'b0;
      end else begin
        off_d = nxt_off;
        rem_d = rem_q - 3'd1;
        word_d = line_q[{nxt_off, 6'b0} +: 64];
        last_d = rem_q == 3'd2;
      end
    end
  end
  // State and output registers; reset aborts any stream in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      line_q <= '0;
      off_q <= '0;
      rem_q <= '0;
      word_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q <= line_d;
      off_q <= off_d;
      rem_q <= rem_d;
      word_q <= word_d;
      last_q <= last_d;
    end
  end
  assign rw.read_word_req_ready_out = state_q == IDLE;
  assign rw.read_word_valid_out = state_q == STREAM;
  assign rw.read_word_word_out = word_q;
  assign rw.read_word_w_off_out = off_q;
  assign rw.read_word_last_out = last_q;
endmodule

// File: tb/tb_l2_read_word.sv
// tb_l2_read_word: directed checks of sub-word reads, wrapping bursts, backpressure, count clamping and reset abort
module tb_l2_read_word;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  l2_read_word_if rw();
  l2_read_word dut (.clk(clk), .rst(rst), .rw(rw));
  always #5 clk = ~clk;
  localparam logic [255:0] BURST = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
  localparam logic [255:0] SUBL = {64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [255:0] l, input logic [1:0] wo, input logic [2:0] bo, input logic [2:0] hs, input logic [2:0] cnt);
    int w = 0;
    while (!rw.read_word_req_ready_out && w < 20) begin
      step();
      w++;
    end
    vectors++;
    if (rw.read_word_req_ready_out !== 1'b1) begin miscompares++; $display("FAIL send_ready got %b want 1", rw.read_word_req_ready_out); end
    rw.read_word_line_in = l;
    rw.read_word_w_off_in = wo;
    rw.read_word_b_off_in = bo;
    rw.read_word_hsize_in = hs;
    rw.read_word_count_in = cnt;
    rw.read_word_req_valid_in = 1'b1;
    step();
    rw.read_word_req_valid_in = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if ({rw.read_word_req_ready_out, rw.read_word_valid_out, rw.read_word_last_out, rw.read_word_w_off_out} !== 5'b10000) begin
      miscompares++; $display("FAIL reset_ctrl got %b want 10000", {rw.read_word_req_ready_out, rw.read_word_valid_out, rw.read_word_last_out, rw.read_word_w_off_out});
    end
    vectors++;
    if (rw.read_word_word_out !== 64'h0) begin miscompares++; $display("FAIL reset_word got %h want 0", rw.read_word_word_out); end
    step();
    rst = 1'b0;
    step();
    vectors++;
    if ({rw.read_word_req_ready_out, rw.read_word_valid_out} !== 2'b10) begin
      miscompares++; $display("FAIL post_reset got %b want 10", {rw.read_word_req_ready_out, rw.read_word_valid_out});
    end
  endtask

  task automatic test_byte;
    send(SUBL, 2'd2, 3'd3, 3'd0, 3'd1);
    vectors++;
    if ({rw.read_word_valid_out, rw.read_word_w_off_out, rw.read_word_last_out, rw.read_word_req_ready_out} !== 5'b11010) begin
      miscompares++; $display("FAIL byte_ctrl got %b want 11010", {rw.read_word_valid_out, rw.read_word_w_off_out, rw.read_word_last_out, rw.read_word_req_ready_out});
    end
    vectors++;
    if (rw.read_word_word_out !== 64'h0000_0000_8900_0000) begin miscompares++; $display("FAIL byte_word got %h want 0000000089000000", rw.read_word_word_out); end
    step();
    vectors++;
    if ({rw.read_word_valid_out, rw.read_word_req_ready_out} !== 2'b01) begin
      miscompares++; $display("FAIL byte_done got %b want 01", {rw.read_word_valid_out, rw.read_word_req_ready_out});
    end
  endtask

  task automatic test_subword;
    logic [2:0]  bo [4] = '{3'd4, 3'd5, 3'd1, 3'd6};
    logic [2:0]  hs [4] = '{3'd1, 3'd2, 3'd1, 3'd3};
    logic [63:0] ex [4] = '{64'h0000_4567_0000_0000, 64'h0123_4567_0000_0000, 64'h0000_0000_0000_CDEF, 64'h0123_4567_89AB_CDEF};
    for (int i = 0; i < 4; i++) begin
      send(SUBL, 2'd2, bo[i], hs[i], 3'd1);
      vectors++;
      if (rw.read_word_word_out !== ex[i] || rw.read_word_last_out !== 1'b1) begin
        miscompares++; $display("FAIL subword%0d got %h last %b want %h last 1", i, rw.read_word_word_out, rw.read_word_last_out, ex[i]);
      end
      step();
      vectors++;
      if (rw.read_word_valid_out !== 1'b0) begin miscompares++; $display("FAIL subword%0d_done valid got %b want 0", i, rw.read_word_valid_out); end
    end
  endtask

  task automatic test_burst;
    logic [63:0] ew [4] = '{64'hA2, 64'hA3, 64'hA0, 64'hA1};
    logic [1:0]  eo [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    send(BURST, 2'd2, 3'd0, 3'd3, 3'd4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rw.read_word_valid_out !== 1'b1 || rw.read_word_word_out !== ew[i] || rw.read_word_w_off_out !== eo[i] || rw.read_word_last_out !== (i == 3)) begin
        miscompares++; $display("FAIL burst_beat%0d got v%b %h off%0d last%b want v1 %h off%0d last%b", i, rw.read_word_valid_out,
          rw.read_word_word_out, rw.read_word_w_off_out, rw.read_word_last_out, ew[i], eo[i], i == 3);
      end
      step();
    end
    vectors++;
    if ({rw.read_word_valid_out, rw.read_word_req_ready_out} !== 2'b01) begin
      miscompares++; $display("FAIL burst_done got %b want 01", {rw.read_word_valid_out, rw.read_word_req_ready_out});
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] ew [4] = '{64'hA2, 64'hA3, 64'hA0, 64'hA1};
    logic [1:0]  eo [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    int hs = 0;
    send(BURST, 2'd2, 3'd0, 3'd3, 3'd4);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        rw.read_word_ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
          vectors++;
          if (rw.read_word_valid_out !== 1'b1 || rw.read_word_word_out !== 64'hA3 || rw.read_word_w_off_out !== 2'd3 || rw.read_word_last_out !== 1'b0) begin
            miscompares++; $display("FAIL stall%0d got v%b %h off%0d last%b want v1 a3 off3 last0", k, rw.read_word_valid_out,
              rw.read_word_word_out, rw.read_word_w_off_out, rw.read_word_last_out);
          end
          step();
        end
        rw.read_word_ready_in = 1'b1;
      end
      vectors++;
      if (rw.read_word_word_out !== ew[i] || rw.read_word_w_off_out !== eo[i] || rw.read_word_last_out !== (i == 3)) begin
        miscompares++; $display("FAIL bp_beat%0d got %h off%0d last%b want %h off%0d last%b", i, rw.read_word_word_out,
          rw.read_word_w_off_out, rw.read_word_last_out, ew[i], eo[i], i == 3);
      end
      if (rw.read_word_valid_out && rw.read_word_ready_in) hs++;
      step();
    end
    for (int k = 0; k < 3; k++) begin
      if (rw.read_word_valid_out && rw.read_word_ready_in) hs++;
      step();
    end
    vectors++;
    if (hs !== 4) begin miscompares++; $display("FAIL bp_handshakes got %0d want 4", hs); end
  endtask

  task automatic test_count;
    int beats = 0;
    send(BURST, 2'd1, 3'd0, 3'd3, 3'd0);
    vectors++;
    if (rw.read_word_word_out !== 64'hA1 || rw.read_word_last_out !== 1'b1 || rw.read_word_w_off_out !== 2'd1) begin
      miscompares++; $display("FAIL count0 got %h last%b off%0d want a1 last1 off1", rw.read_word_word_out, rw.read_word_last_out, rw.read_word_w_off_out);
    end
    step();
    vectors++;
    if (rw.read_word_valid_out !== 1'b0) begin miscompares++; $display("FAIL count0_done valid got %b want 0", rw.read_word_valid_out); end
    send(BURST, 2'd0, 3'd0, 3'd0, 3'd7);
    rw.read_word_w_off_in = 2'd3;
    rw.read_word_count_in = 3'd2;
    rw.read_word_req_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rw.read_word_req_ready_out !== 1'b0 || rw.read_word_valid_out !== 1'b1 || rw.read_word_word_out !== 64'(160 + i) || rw.read_word_last_out !== (i == 3)) begin
        miscompares++; $display("FAIL count7_beat%0d got rdy%b v%b %h last%b want rdy0 v1 %h last%b", i, rw.read_word_req_ready_out,
          rw.read_word_valid_out, rw.read_word_word_out, rw.read_word_last_out, 64'(160 + i), i == 3);
      end
      if (rw.read_word_valid_out) beats++;
      step();
    end
    vectors++;
    if ({rw.read_word_valid_out, rw.read_word_req_ready_out, beats[2:0]} !== 5'b01100) begin
      miscompares++; $display("FAIL count7_done got v%b rdy%b beats%0d want v0 rdy1 beats4", rw.read_word_valid_out, rw.read_word_req_ready_out, beats);
    end
    step();
    rw.read_word_req_valid_in = 1'b0;
    vectors++;
    if (rw.read_word_valid_out !== 1'b1 || rw.read_word_word_out !== 64'hA3 || rw.read_word_w_off_out !== 2'd3 || rw.read_word_last_out !== 1'b0) begin
      miscompares++; $display("FAIL second_beat0 got v%b %h off%0d last%b want v1 a3 off3 last0", rw.read_word_valid_out,
        rw.read_word_word_out, rw.read_word_w_off_out, rw.read_word_last_out);
    end
    step();
    vectors++;
    if (rw.read_word_word_out !== 64'hA0 || rw.read_word_w_off_out !== 2'd0 || rw.read_word_last_out !== 1'b1) begin
      miscompares++; $display("FAIL second_beat1 got %h off%0d last%b want a0 off0 last1", rw.read_word_word_out, rw.read_word_w_off_out, rw.read_word_last_out);
    end
    step();
    vectors++;
    if (rw.read_word_valid_out !== 1'b0) begin miscompares++; $display("FAIL second_done valid got %b want 0", rw.read_word_valid_out); end
  endtask

  task automatic test_reset_mid;
    send(BURST, 2'd0, 3'd0, 3'd3, 3'd4);
    vectors++;
    if (rw.read_word_word_out !== 64'hA0) begin miscompares++; $display("FAIL rm_beat0 got %h want a0", rw.read_word_word_out); end
    step();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({rw.read_word_valid_out, rw.read_word_last_out, rw.read_word_req_ready_out} !== 3'b001) begin
      miscompares++; $display("FAIL rm_abort got v%b last%b rdy%b want v0 last0 rdy1", rw.read_word_valid_out, rw.read_word_last_out, rw.read_word_req_ready_out);
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (rw.read_word_valid_out !== 1'b0 || rw.read_word_req_ready_out !== 1'b1) begin
        miscompares++; $display("FAIL rm_idle%0d got v%b rdy%b want v0 rdy1", k, rw.read_word_valid_out, rw.read_word_req_ready_out);
      end
      step();
    end
    send(BURST, 2'd1, 3'd0, 3'd3, 3'd1);
    vectors++;
    if (rw.read_word_valid_out !== 1'b1 || rw.read_word_word_out !== 64'hA1 || rw.read_word_last_out !== 1'b1) begin
      miscompares++; $display("FAIL rm_after got v%b %h last%b want v1 a1 last1", rw.read_word_valid_out, rw.read_word_word_out, rw.read_word_last_out);
    end
    step();
    vectors++;
    if (rw.read_word_valid_out !== 1'b0) begin miscompares++; $display("FAIL rm_after_done valid got %b want 0", rw.read_word_valid_out); end
  endtask

  initial begin
    rw.read_word_req_valid_in = 1'b0;
    rw.read_word_line_in = '0;
    rw.read_word_w_off_in = '0;
    rw.read_word_b_off_in = '0;
    rw.read_word_hsize_in = '0;
    rw.read_word_count_in = '0;
    rw.read_word_ready_in = 1'b1;
    test_reset();
    test_byte();
    test_subword();
    test_burst();
    test_backpressure();
    test_count();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d vectors", vectors);
    $fatal(1, "timeout");
  end
endmodule
